// File: rtl/asub_pkg.sv
// asub_pkg: shared width constants and result type for the a_subtract_b datapath
package asub_pkg;
  localparam int ASUB_DEFAULT_N = 4;
  localparam int ASUB_MAX_N = 32;
  typedef struct packed {
    logic [ASUB_MAX_N:0] diff;
    logic                borrow;
  } asub_result_t;
endpackage

// File: rtl/a_sub_bit.sv
// a_sub_bit: one-bit full subtractor, d = a - b - bin with borrow out
module a_sub_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/a_subtract_b.sv
// a_subtract_b: registered N+1-bit unsigned A-B via ripple-borrow chain; ASUB_SATURATE_EN clamps underflow to 0
module a_subtract_b
  import asub_pkg::*;
#(
  parameter int N = ASUB_DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         out_valid,
  output logic [N:0]   S,
  output logic         borrow
);
  logic [N:0]   bw;
  logic [N-1:0] d;
  logic [N:0]   s_nxt;
  assign bw[0] = 1'b0;
  for (genvar g = 0; g < N; g++) begin : g_chain
    a_sub_bit u_bit (
      .a(A[g]),
      .b(B[g]),
      .bin(bw[g]),
      .d(d[g]),
      .bout(bw[g+1])
    );
  end
  // zero-extended operands make the top difference bit equal the final borrow
`ifdef ASUB_SATURATE_EN
  assign s_nxt = bw[N] ? '0 : {bw[N], d};
`else
  assign s_nxt = {bw[N], d};
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      S <= '0;
      borrow <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        S <= s_nxt;
        borrow <= bw[N];
      end
    end
  end
endmodule

// File: tb/tb_a_subtract_b.sv
// tb_a_subtract_b: directed and exhaustive checks of a_subtract_b at N=4 (honours ASUB_SATURATE_EN)
module tb_a_subtract_b;
`ifdef ASUB_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic       out_valid;
  logic [4:0] s;
  logic       borrow;
  int vecs = 0;
  int errs = 0;

  a_subtract_b #(.N(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .A(a),
    .B(b),
    .out_valid(out_valid),
    .S(s),
    .borrow(borrow)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    in_valid = 1'b1;
    a = 4'hF;
    b = 4'h1;
    for (int i = 0; i < 3; i++) begin
      step();
      vecs++;
      if ({out_valid, borrow, s} !== 7'b0) begin
        errs++;
        $display("FAIL reset[%0d]: got ov=%b borrow=%b S=%b, want ov=0 borrow=0 S=00000", i, out_valid, borrow, s);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed;
    logic [3:0] ta [3] = '{4'd5, 4'd15, 4'd0};
    logic [3:0] tb [3] = '{4'd2, 4'd6, 4'd0};
    logic [4:0] ts [3] = '{5'b00011, 5'b01001, 5'b00000};
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a = ta[i];
      b = tb[i];
      step();
      vecs++;
      if ({out_valid, borrow, s} !== {1'b1, 1'b0, ts[i]}) begin
        errs++;
        $display("FAIL directed %0d-%0d: got ov=%b borrow=%b S=%b, want ov=1 borrow=0 S=%b", ta[i], tb[i], out_valid, borrow, s, ts[i]);
      end
    end
  endtask

  task automatic test_underflow_boundary;
    logic [3:0] ta [3] = '{4'd2, 4'd15, 4'd0};
    logic [3:0] tb [3] = '{4'd5, 4'd0, 4'd15};
    logic [4:0] ts [3];
    logic       tbw [3] = '{1'b1, 1'b0, 1'b1};
    ts[0] = SAT ? 5'b00000 : 5'b11101;
    ts[1] = 5'b01111;
    ts[2] = SAT ? 5'b00000 : 5'b10001;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a = ta[i];
      b = tb[i];
      step();
      vecs++;
      if ({out_valid, borrow, s} !== {1'b1, tbw[i], ts[i]}) begin
        errs++;
        $display("FAIL edge %0d-%0d: got ov=%b borrow=%b S=%b, want ov=1 borrow=%b S=%b", ta[i], tb[i], out_valid, borrow, s, tbw[i], ts[i]);
      end
    end
  endtask

  task automatic test_hold;
    in_valid = 1'b1;
    a = 4'd9;
    b = 4'd4;
    step();
    vecs++;
    if ({out_valid, borrow, s} !== {1'b1, 1'b0, 5'd5}) begin
      errs++;
      $display("FAIL hold_load: got ov=%b borrow=%b S=%b, want ov=1 borrow=0 S=00101", out_valid, borrow, s);
    end
    in_valid = 1'b0;
    a = 4'd1;
    b = 4'd8;
    for (int i = 0; i < 2; i++) begin
      step();
      vecs++;
      if ({out_valid, borrow, s} !== {1'b0, 1'b0, 5'd5}) begin
        errs++;
        $display("FAIL hold[%0d]: got ov=%b borrow=%b S=%b, want ov=0 borrow=0 S=00101", i, out_valid, borrow, s);
      end
    end
  endtask

  task automatic test_midstream_reset;
    in_valid = 1'b1;
    a = 4'd7;
    b = 4'd3;
    step();
    vecs++;
    if ({out_valid, borrow, s} !== {1'b1, 1'b0, 5'd4}) begin
      errs++;
      $display("FAIL mid_7_3: got ov=%b borrow=%b S=%b, want ov=1 borrow=0 S=00100", out_valid, borrow, s);
    end
    a = 4'd3;
    b = 4'd7;
    step();
    vecs++;
    if ({out_valid, borrow, s} !== {1'b1, 1'b1, SAT ? 5'd0 : 5'b11100}) begin
      errs++;
      $display("FAIL mid_3_7: got ov=%b borrow=%b S=%b, want ov=1 borrow=1 S=%b", out_valid, borrow, s, SAT ? 5'd0 : 5'b11100);
    end
    rst_n = 1'b0;
    a = 4'd5;
    b = 4'd1;
    step();
    vecs++;
    if ({out_valid, borrow, s} !== 7'b0) begin
      errs++;
      $display("FAIL mid_reset: got ov=%b borrow=%b S=%b, want ov=0 borrow=0 S=00000", out_valid, borrow, s);
    end
    rst_n = 1'b1;
    in_valid = 1'b0;
    step();
    vecs++;
    if ({out_valid, borrow, s} !== 7'b0) begin
      errs++;
      $display("FAIL mid_idle: got ov=%b borrow=%b S=%b, want ov=0 borrow=0 S=00000", out_valid, borrow, s);
    end
    in_valid = 1'b1;
    a = 4'd6;
    b = 4'd1;
    step();
    vecs++;
    if ({out_valid, borrow, s} !== {1'b1, 1'b0, 5'd5}) begin
      errs++;
      $display("FAIL mid_first: got ov=%b borrow=%b S=%b, want ov=1 borrow=0 S=00101", out_valid, borrow, s);
    end
  endtask

  task automatic test_sweep;
    logic [4:0] w;
    logic [4:0] es;
    logic       eb;
    in_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      a = 4'(i >> 4);
      b = 4'(i);
      w = {1'b0, a} - {1'b0, b};
      eb = a < b;
      es = (SAT && eb) ? 5'd0 : w;
      step();
      vecs++;
      if ({out_valid, borrow, s} !== {1'b1, eb, es}) begin
        errs++;
        $display("FAIL sweep %0d-%0d: got ov=%b borrow=%b S=%b, want ov=1 borrow=%b S=%b", a, b, out_valid, borrow, s, eb, es);
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_underflow_boundary();
    test_hold();
    test_midstream_reset();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
